// File: rtl/hex_keypad_scanner_pkg.sv
// Shared types and helpers for the hex keypad scanner: FSM states, frame classes
// and the frame classifier.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_ONE,
    FR_MULTI
  } frame_e;

  typedef struct packed {
    frame_e              cls;
    logic [CODE_W-1:0]   code;
  } frame_info_t;

  // pressed[col*NUM_ROWS + row] is 1 when that key read low during the frame.
  function automatic frame_info_t classify_frame(input logic [NUM_ROWS*NUM_COLS-1:0] pressed);
    frame_info_t info;
    logic [1:0]  n;
    logic [3:0]  idx;
    n         = 2'd0;
    info.code = '0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      idx = 4'(i);
      if (pressed[i]) begin
        if (n != 2'd2) n = n + 2'd1;
        info.code = {idx[1:0], idx[3:2]};
      end
    end
    case (n)
      2'd0:    info.cls = FR_NONE;
      2'd1:    info.cls = FR_ONE;
      default: info.cls = FR_MULTI;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/hex_keypad_scanner_scan_tick_gen.sv
// Scan-rate enable generator: one-cycle tick every CLK_DIV+1 clk cycles.
module scan_tick_gen #(
  parameter int CLK_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick = (div_cnt == CNT_W'(CLK_DIV));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, row synchronizer, frame classifier,
// debounce FSM and a 4-digit shift register feeding the display bus.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_DIV         = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic [15:0]         data
);

  localparam int              CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DF_C  = CNT_W'(DEBOUNCE_FRAMES);
  localparam bit              DF_ONE = (DEBOUNCE_FRAMES == 1);

  logic                          tick;
  logic [NUM_ROWS-1:0]           rows_meta, rows_s;
  logic [1:0]                    col_idx;
  logic [NUM_ROWS*NUM_COLS-1:0]  frame_acc;
  logic                          frame_done;
  frame_info_t                   finfo;

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CODE_W-1:0] cand, cand_nx;
  logic              accept;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign cols_n = ~(4'b0001 << col_idx);

  // Synchronizer, column scan and frame accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_meta  <= 4'hF;
      rows_s     <= 4'hF;
      col_idx    <= 2'd0;
      frame_acc  <= '0;
      frame_done <= 1'b0;
    end else begin
      rows_meta  <= rows_n;
      rows_s     <= rows_meta;
      frame_done <= tick && (col_idx == 2'd3);
      if (tick) begin
        frame_acc[{col_idx, 2'b00} +: NUM_ROWS] <= ~rows_s;
        col_idx                                 <= col_idx + 2'd1;
      end
    end
  end

  assign finfo = classify_frame(frame_acc);

  // Debounce FSM, evaluated once per completed frame
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (frame_done) begin
      case (state)
        ST_IDLE: begin
          if (finfo.cls == FR_ONE) begin
            cand_nx = finfo.code;
            if (DF_ONE) begin
              state_nx = ST_HELD;
              cnt_nx   = '0;
              accept   = 1'b1;
            end else begin
              state_nx = ST_DEBOUNCE;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (finfo.cls == FR_ONE) begin
            if (finfo.code == cand) begin
              if (cnt + 1'b1 == DF_C) begin
                state_nx = ST_HELD;
                cnt_nx   = '0;
                accept   = 1'b1;
              end else begin
                cnt_nx = cnt + 1'b1;
              end
            end else begin
              cand_nx = finfo.code;
              cnt_nx  = CNT_W'(1);
            end
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end
        end
        ST_HELD: begin
          if (finfo.cls == FR_NONE) begin
            if (DF_ONE) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              state_nx = ST_RELEASE;
              cnt_nx   = CNT_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (finfo.cls == FR_NONE) begin
            if (cnt + 1'b1 == DF_C) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            state_nx = ST_HELD;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      data      <= 16'h0000;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      cand      <= cand_nx;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_nx;
        data     <= {data[11:0], cand_nx};
      end
    end
  end

  // Held through the release debounce so the key counts as down until it is accepted as up
  assign key_held = (state == ST_HELD) || (state == ST_RELEASE);

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner with a keypad matrix model and an
// event-level model of accepted key codes and the display shift register.
module tb_hex_keypad_scanner;

  localparam int CLK_DIV = 3;
  localparam int DF      = 2;
  localparam int FRAME   = 4 * (CLK_DIV + 1);
  localparam int LAT_MAX = (DF + 1) * 4 * (CLK_DIV + 1) + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] data;

  logic [15:0] keys = 16'h0000;  // keys[row*4+col] pressed
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          vcount    = 0;
  logic [3:0]  last_code = 4'h0;
  logic [15:0] dm        = 16'h0000;

  hex_keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .data      (data)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && cols_n[c] == 1'b0) rows_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      vcount    = vcount + 1;
      last_code = key_code;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    keys = 16'h0000;
    @(negedge clk);
    rst  = 1'b0;
    dm   = 16'h0000;
  endtask

  // Stable single press long enough to debounce, then a debounced release.
  task automatic press_release(input logic [3:0] code, input int hold_frames, input int gap_frames);
    keys = 16'h0001 << code;
    wait_clks(hold_frames * FRAME);
    keys = 16'h0000;
    wait_clks(gap_frames * FRAME);
    dm = {dm[11:0], code};
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    int col, base;
    do_reset();
    total_cnt++; if (cols_n !== 4'b1110) $display("FAIL reset_cols_n got %b want %b", cols_n, 4'b1110); else pass_cnt++;
    total_cnt++; if (data !== 16'h0000) $display("FAIL reset_data got %h want 0000", data); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid got %b want 0", key_valid); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL reset_key_held got %b want 0", key_held); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h0) $display("FAIL reset_key_code got %h want 0", key_code); else pass_cnt++;
    base = vcount;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      col = (k / (CLK_DIV + 1)) % 4;
      exp = 4'hF;
      exp[col] = 1'b0;
      total_cnt++; if (cols_n !== exp) $display("FAIL scan_cols_n cycle %0d got %b want %b", k, cols_n, exp); else pass_cnt++;
    end
    total_cnt++; if (vcount !== base) $display("FAIL idle_no_valid got %0d want %0d", vcount, base); else pass_cnt++;
  endtask

  task automatic test_single_press();
    int base, lat;
    bit seen;
    do_reset();
    base = vcount;
    seen = 1'b0;
    lat  = 0;
    keys = 16'h0001 << 6;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge clk);
      if (vcount != base) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    total_cnt++; if (!seen) $display("FAIL press_timeout got no key_valid want one within 200 cycles"); else pass_cnt++;
    total_cnt++; if (lat > LAT_MAX) $display("FAIL press_latency got %0d want <= %0d", lat, LAT_MAX); else pass_cnt++;
    wait_clks(3 * FRAME);
    dm = {dm[11:0], 4'h6};
    total_cnt++; if (vcount - base !== 1) $display("FAIL press_pulses got %0d want 1", vcount - base); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h6) $display("FAIL press_key_code got %h want 6", key_code); else pass_cnt++;
    total_cnt++; if (data !== 16'h0006) $display("FAIL press_data got %h want 0006", data); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b1) $display("FAIL press_held got %b want 1", key_held); else pass_cnt++;
    keys = 16'h0000;
    wait_clks(5 * FRAME);
    total_cnt++; if (key_held !== 1'b0) $display("FAIL release_held got %b want 0", key_held); else pass_cnt++;
    total_cnt++; if (vcount - base !== 1) $display("FAIL release_pulses got %0d want 1", vcount - base); else pass_cnt++;
  endtask

  task automatic test_sequence();
    int base;
    base = vcount;
    for (int d = 1; d <= 5; d++) begin
      press_release(4'(d), $urandom_range(4, 6), $urandom_range(4, 6));
      total_cnt++; if (last_code !== 4'(d)) $display("FAIL seq_code digit %0d got %h want %h", d, last_code, 4'(d)); else pass_cnt++;
    end
    total_cnt++; if (data !== 16'h2345) $display("FAIL seq_data got %h want 2345", data); else pass_cnt++;
    total_cnt++; if (vcount - base !== 5) $display("FAIL seq_pulses got %0d want 5", vcount - base); else pass_cnt++;
  endtask

  task automatic test_bounce();
    int base;
    base = vcount;
    keys = 16'h0001;
    wait_clks(FRAME - 6);
    keys = 16'h0000;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount !== base) $display("FAIL bounce_no_valid got %0d want %0d", vcount, base); else pass_cnt++;
    press_release(4'h0, 3, 5);
    total_cnt++; if (vcount - base !== 1) $display("FAIL bounce_hold_pulses got %0d want 1", vcount - base); else pass_cnt++;
    total_cnt++; if (last_code !== 4'h0) $display("FAIL bounce_hold_code got %h want 0", last_code); else pass_cnt++;
    total_cnt++; if (data !== dm) $display("FAIL bounce_hold_data got %h want %h", data, dm); else pass_cnt++;
  endtask

  task automatic test_multi();
    int base;
    base = vcount;
    keys = 16'h8001;
    wait_clks(6 * FRAME);
    keys = 16'h0000;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount !== base) $display("FAIL multi_idle_no_valid got %0d want %0d", vcount, base); else pass_cnt++;
    keys = 16'h0040;
    wait_clks(5 * FRAME);
    dm = {dm[11:0], 4'h6};
    keys = 16'h0041;
    wait_clks(4 * FRAME);
    total_cnt++; if (key_held !== 1'b1) $display("FAIL multi_held got %b want 1", key_held); else pass_cnt++;
    keys = 16'h0040;
    wait_clks(2 * FRAME);
    keys = 16'h0000;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount - base !== 1) $display("FAIL multi_held_pulses got %0d want 1", vcount - base); else pass_cnt++;
    total_cnt++; if (data !== dm) $display("FAIL multi_data got %h want %h", data, dm); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int base;
    keys = 16'h0001 << 5;
    wait_clks(FRAME + 4);
    do_reset();
    total_cnt++; if (cols_n !== 4'b1110) $display("FAIL rstdeb_cols_n got %b want 1110", cols_n); else pass_cnt++;
    total_cnt++; if (data !== 16'h0000) $display("FAIL rstdeb_data got %h want 0000", data); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL rstdeb_held got %b want 0", key_held); else pass_cnt++;
    base = vcount;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount !== base) $display("FAIL rstdeb_no_valid got %0d want %0d", vcount, base); else pass_cnt++;
    keys = 16'h0001 << 9;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount - base !== 1) $display("FAIL rstheld_press got %0d want 1", vcount - base); else pass_cnt++;
    do_reset();
    total_cnt++; if (key_code !== 4'h0) $display("FAIL rstheld_key_code got %h want 0", key_code); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL rstheld_held got %b want 0", key_held); else pass_cnt++;
    total_cnt++; if (data !== 16'h0000) $display("FAIL rstheld_data got %h want 0000", data); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL rstheld_valid got %b want 0", key_valid); else pass_cnt++;
    base = vcount;
    wait_clks(5 * FRAME);
    total_cnt++; if (vcount !== base) $display("FAIL rstheld_no_valid got %0d want %0d", vcount, base); else pass_cnt++;
    press_release(4'hA, 4, 5);
    total_cnt++; if (data !== 16'h000A) $display("FAIL fresh_data got %h want 000A", data); else pass_cnt++;
    total_cnt++; if (last_code !== 4'hA) $display("FAIL fresh_code got %h want A", last_code); else pass_cnt++;
  endtask

  task automatic test_random();
    int base, kind, a, b, exp_cnt;
    logic [3:0] code;
    base    = vcount;
    exp_cnt = 0;
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 2);
      code = 4'($urandom_range(0, 15));
      if (kind == 0) begin
        press_release(code, $urandom_range(4, 6), $urandom_range(4, 6));
        exp_cnt++;
        total_cnt++; if (last_code !== code) $display("FAIL rand_code iter %0d got %h want %h", it, last_code, code); else pass_cnt++;
      end else if (kind == 1) begin
        keys = 16'h0001 << code;
        wait_clks($urandom_range(3, 12));
        keys = 16'h0000;
        wait_clks(5 * FRAME);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        keys = (16'h0001 << a) | (16'h0001 << b);
        wait_clks($urandom_range(4, 6) * FRAME);
        keys = 16'h0000;
        wait_clks(5 * FRAME);
      end
      total_cnt++; if (vcount - base !== exp_cnt) $display("FAIL rand_pulses iter %0d got %0d want %0d", it, vcount - base, exp_cnt); else pass_cnt++;
      total_cnt++; if (data !== dm) $display("FAIL rand_data iter %0d got %h want %h", it, data, dm); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_bounce();
    test_multi();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
